// File: rtl/ssdec_scan.sv
// Scanned driver for a bank of common-cathode 7-segment digits on a shared segment bus.
// One digit is shown per refresh slot. The display image is double-buffered and only swaps at frame boundaries.
module ssdec_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic                  pend_q, pend_d;
  logic [VW-1:0]         stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0] stg_en_q, stg_en_d;
  logic [VW-1:0]         shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] shd_en_q, shd_en_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  boundary;
  logic                  run_zero;
  logic [NUM_DIGITS-1:0] lz_vec;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_lz;
  logic                  blanked;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h67;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IW'(NUM_DIGITS - 1));

    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = boundary ? '0 : idx_q + IW'(1);
    frame_done_d = boundary;

    // Staging always takes the newest load, including one on the boundary cycle,
    // while the shadow copies the pre-load staging contents on that same edge.
    stg_val_d = stg_val_q;
    stg_dp_d  = stg_dp_q;
    stg_en_d  = stg_en_q;
    pend_d    = pend_q;
    if (boundary) pend_d = 1'b0;
    if (load) begin
      stg_val_d = value;
      stg_dp_d  = dp_in;
      stg_en_d  = digit_en;
      pend_d    = 1'b1;
    end

    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    shd_en_d  = shd_en_q;
    if (boundary && pend_q) begin
      shd_val_d = stg_val_q;
      shd_dp_d  = stg_dp_q;
      shd_en_d  = stg_en_q;
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (boundary) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // lz_vec[i] is set when shadow nibbles from the top digit down to i are all zero.
    run_zero = 1'b1;
    lz_vec   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero  = run_zero & (shd_val_q[4*i +: 4] == 4'h0);
      lz_vec[i] = run_zero;
    end

    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    an_d    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = shd_val_q[4*i +: 4];
        cur_dp   = shd_dp_q[i];
        cur_en   = shd_en_q[i];
        cur_lz   = lz_vec[i];
        an_d[i]  = 1'b1;
      end
    end

    blanked = blank_lz && cur_lz && (idx_q != '0);
    seg_d   = {cur_dp, blanked ? 7'h00 : seg7(cur_nib)};
    if (!cur_en || (blink_en && blink_ph_q)) seg_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pend_q       <= 1'b0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_en_q     <= '0;
      seg_q        <= 8'h00;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_q       <= pend_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_en_q     <= shd_en_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssdec_scan.sv
// Directed bench for ssdec_scan with 4 digits, 4-cycle slots and 2-frame blink half-period.
module tb_ssdec_scan;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        blink_en;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  ssdec_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .blink_en(blink_en),
    .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // Returns the number of cycles until frame_done is seen high.
  task automatic wait_fd(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 200);
    if (cnt >= 200) chk("fd_timeout", 32'(cnt), 32'd0);
  endtask

  // Leaves the bench on the first cycle digit 0 of the new frame is visible.
  task automatic sync_frame();
    int c;
    wait_fd(c);
    step(1);
    chk("fd_one_cycle", 32'(frame_done), 32'd0);
  endtask

  // exp holds {digit3, digit2, digit1, digit0} segment bytes.
  task automatic scan_frame(input string tag, input logic [31:0] exp);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(4);
      a = 4'b0001 << i;
      chk({tag, "_an"}, 32'(an_out), 32'(a));
      chk({tag, "_seg"}, 32'(seg_out), 32'(exp[8*i +: 8]));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    value = v; dp_in = dp; digit_en = en; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
    blank_lz = 1'b0; blink_en = 1'b0;
    step(3);
    chk("rst_seg", 32'(seg_out), 32'h00);
    chk("rst_an", 32'(an_out), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("first_an", 32'(an_out), 32'h1);

    // Idle scanning: dark segments, walking anode, 16-cycle frame.
    wait_fd(n);
    wait_fd(n);
    chk("fd_period", 32'(n), 32'd16);
    step(1);
    scan_frame("idle", 32'h00000000);

    // Mid-frame load must not disturb the current frame.
    sync_frame();
    step(6);
    do_load(16'h1A80, 4'b0100, 4'b1111);
    chk("no_tear_seg", 32'(seg_out), 32'h00);
    sync_frame();
    scan_frame("load1a80", {8'h06, 8'hF7, 8'h7F, 8'h3F});

    // Two loads in one frame: newest wins.
    sync_frame();
    step(2);
    do_load(16'h1111, 4'b0000, 4'b1111);
    step(3);
    do_load(16'h2222, 4'b0000, 4'b1111);
    sync_frame();
    scan_frame("newest", {8'h5B, 8'h5B, 8'h5B, 8'h5B});

    // Load on the boundary cycle is held over to the following frame.
    sync_frame();
    step(14);
    value = 16'h1111; dp_in = 4'b0000; digit_en = 4'b1111; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("bnd_fd", 32'(frame_done), 32'd1);
    step(1);
    scan_frame("bnd_old", {8'h5B, 8'h5B, 8'h5B, 8'h5B});
    sync_frame();
    scan_frame("bnd_new", {8'h06, 8'h06, 8'h06, 8'h06});

    // Leading-zero blanking and masking.
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b1111);
    sync_frame();
    scan_frame("lz0070", {8'h00, 8'h00, 8'h07, 8'h3F});
    do_load(16'h0000, 4'b0000, 4'b1111);
    sync_frame();
    scan_frame("lz0000", {8'h00, 8'h00, 8'h00, 8'h3F});
    do_load(16'h0000, 4'b0100, 4'b1111);
    sync_frame();
    scan_frame("lz_dp", {8'h00, 8'h80, 8'h00, 8'h3F});
    blank_lz = 1'b0;
    sync_frame();
    scan_frame("lz_off", {8'h3F, 8'hBF, 8'h3F, 8'h3F});
    do_load(16'h8888, 4'b1111, 4'b1010);
    sync_frame();
    scan_frame("mask", {8'hFF, 8'h00, 8'hFF, 8'h00});

    // Blink from a fresh reset so the phase sequence is known.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    blink_en = 1'b1;
    do_load(16'h8888, 4'b0000, 4'b1111);
    sync_frame(); scan_frame("blink1", {4{8'h7F}});
    sync_frame(); scan_frame("blink2", {4{8'h00}});
    sync_frame(); scan_frame("blink3", {4{8'h00}});
    sync_frame(); scan_frame("blink4", {4{8'h7F}});
    sync_frame(); scan_frame("blink5", {4{8'h7F}});
    sync_frame(); scan_frame("blink6", {4{8'h00}});
    blink_en = 1'b0;

    // Reset with a load pending: dark immediately and the load is lost.
    do_load(16'h8888, 4'b1111, 4'b1111);
    rst_n = 1'b0;
    step(1);
    chk("rst2_seg", 32'(seg_out), 32'h00);
    chk("rst2_an", 32'(an_out), 32'h0);
    chk("rst2_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    sync_frame();
    scan_frame("after_rst1", 32'h00000000);
    sync_frame();
    scan_frame("after_rst2", 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
